// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver. Delivers a byte plus a one-cycle strobe.
// Start glitches are dropped, and framing errors are flagged instead of delivered.
module uart_rx_os16 #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       data,
  output logic [7:0] character,
  output logic       dataReady,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV    = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t              state, state_nxt;
  logic                sync1, rx_s;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [3:0]          sample_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                sample_last;

  // Two-flop synchronizer; the line idles high, so reset to 1 avoids a false start.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= data;
      rx_s  <= sync1;
    end
  end

  // The divider is cleared in IDLE so it realigns to each start edge.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)                        tick_cnt <= '0;
    else if (state == IDLE || tick)    tick_cnt <= '0;
    else                               tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign tick        = (tick_cnt == TICK_W'(DIV - 1));
  assign sample_last = tick && (sample_cnt == 4'd15);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick && sample_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (sample_last && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (sample_last) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      character  <= '0;
      dataReady  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          bit_idx    <= '0;
        end
        START: begin
          // Mid-start-bit point: zero the counter so later samples land mid-bit.
          if (tick) sample_cnt <= (sample_cnt == 4'd7) ? 4'd0 : sample_cnt + 4'd1;
        end
        DATA: begin
          if (tick) sample_cnt <= sample_cnt + 4'd1;
          if (sample_last) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick) sample_cnt <= sample_cnt + 4'd1;
          if (sample_last) begin
            if (rx_s) begin
              character <= shreg;
              dataReady <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
16x-oversampled UART receiver (8N1, LSB first) sitting directly upstream of the UART loader top. It feeds the loader's byte-write path with a received byte plus a one-cycle strobe. Its internal baud divider realigns on every start edge, which tolerates clock/baud mismatch. It also rejects start glitches and flags framing errors so bad bytes never reach memory.

Parameters:
CLK_FREQ  50000000  system clock frequency, Hz
BAUD  115200  line rate, bits/s
DIV  (CLK_FREQ + BAUD*8)/(BAUD*16)  clocks per oversample tick, rounded to nearest; must be >= 2

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
data  input  1  serial RX line, asynchronous to clk, idle high
character  output  8  last correctly framed byte
dataReady  output  1  one-cycle strobe: character updated this cycle
frame_err  output  1  one-cycle strobe: stop bit sampled low, byte discarded
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; character=8'h00; dataReady=0; frame_err=0; busy=0.
  - Both sync flops=1; tick counter, sample counter, bit index and shift register all 0.
- Input sync: data passes through 2 flops to give rx_s; all decisions use rx_s only.
- Tick generator:
  - tick_cnt counts 0..DIV-1 and wraps; tick=1 for the one cycle when tick_cnt==DIV-1.
  - Held at 0 while in IDLE, so the first tick after leaving IDLE comes exactly DIV cycles later.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. sample_cnt is 4 bits and counts ticks.
  - IDLE: rx_s==0 -> START, sample_cnt=0.
  - START, on tick: sample_cnt increments.
    - At the 8th tick (sample_cnt==7 on that tick), rx_s==0 -> DATA with sample_cnt=0, bit_idx=0.
    - At the same point, rx_s==1 -> glitch -> IDLE. No strobes.
  - DATA, on tick: when sample_cnt==15, shift right with shreg[7]=rx_s, sample_cnt=0, bit_idx++.
    - After bit_idx 7 is sampled -> STOP. Byte = first-received bit in bit 0.
  - STOP, on tick with sample_cnt==15:
    - rx_s==1: character<=shreg, dataReady=1 for one cycle, -> IDLE.
    - rx_s==0: frame_err=1 for one cycle, character unchanged, no dataReady, -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1, then -> IDLE. A break (line held low) yields exactly one frame_err and no phantom bytes.
- Latency: dataReady rises 152*DIV+3 cycles (+/-1) after the falling edge on data. That is 8+16*9 ticks, plus 2 sync cycles, plus 1 for the IDLE transition.
- dataReady and frame_err are never high in the same cycle. Each is high for exactly 1 clk per frame.
- Back-to-back frames: a start bit immediately after the stop-bit sample must be caught.
  - The FSM returns to IDLE at mid-stop-bit, so the next falling edge 8 ticks later is detected.
  - The consumer must take character within 160*DIV cycles; it holds its value until the next good frame.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is lost and no strobe is issued.
- busy=1 throughout START/DATA/STOP/WAIT_HIGH and drops in the cycle the state returns to IDLE.

Test Plan:
- Bench parameters: CLK_FREQ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clk.
- Send byte 8'hA5 (8N1) -> one dataReady pulse 1523+/-1 cycles after the start edge; character=8'hA5; frame_err never 1.
- Send 8'h00 then 8'hFF back-to-back with zero idle gap -> exactly two dataReady pulses, 1600 cycles apart; character=8'h00 then 8'hFF.
- Low glitch of 40 clk on an idle line -> no strobes; busy high for about 80 clk, then 0; character unchanged.
- Frame 8'h3C with stop bit forced low, then line held low for 3000 clk, then released and 8'h81 sent:
  - exactly one frame_err, no dataReady during the break;
  - then dataReady with character=8'h81.
- Sender clock skewed +3% and -3% while sending 0x55, 0xAA, 0x0F -> all three received correctly.
- Assert Reset low for 5 clk during bit 4 of 8'hC3, release, then send 8'h7E:
  - outputs at reset values immediately, with no strobe for the aborted byte;
  - then a single dataReady with character=8'h7E.
